lcd1602_reader: RTL and testbench

//   Read-side engine for the HD44780/LCD1602 bus (RW=1 cycles). It is the counterpart of the

---
 rtl/lcd1602_reader_if.sv | 24 ++
 rtl/lcd1602_reader.sv | 200 ++++++++++++++++++++
 tb/tb_lcd1602_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_reader_if.sv
// Request/response bundle between a host and the LCD1602 read engine.
// The host drives req/op; the engine returns status and captured read data.
interface lcd1602_reader_if;
  logic       req;
  logic [1:0] op;
  logic       ready;
  logic       done;
  logic       err;
  logic       timeout;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic [9:0] poll_count;

  modport master (
    output req, op,
    input  ready, done, err, timeout, rd_data, busy_flag, addr_cnt, poll_count
  );

  modport slave (
    input  req, op,
    output ready, done, err, timeout, rd_data, busy_flag, addr_cnt, poll_count
  );
endinterface

// File: rtl/lcd1602_reader.sv
// HD44780/LCD1602 read-side engine: status read, data read, or busy-flag poll.
// Releases the DB bus (lcd_db_oe=0) for the whole read window and returns it on completion.
module lcd1602_reader #(
  parameter int unsigned T_AS      = 3,
  parameter int unsigned T_PW      = 12,
  parameter int unsigned T_H       = 3,
  parameter int unsigned T_GAP     = 10,
  parameter int unsigned MAX_POLLS = 1023
) (
  input  logic                    master_clk,
  input  logic                    rs,
  lcd1602_reader_if.slave         bus,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic                    lcd_e,
  input  logic [7:0]              lcd_db_in,
  output logic                    lcd_db_oe
);

  localparam int unsigned PhMax01 = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int unsigned PhMax23 = (T_H > T_GAP) ? T_H : T_GAP;
  localparam int unsigned PhMax   = (PhMax01 > PhMax23) ? PhMax01 : PhMax23;
  localparam int unsigned CntW    = (PhMax > 1) ? $clog2(PhMax) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StEHi, StHold, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            busy_flag_q, busy_flag_d;
  logic [6:0]      addr_cnt_q, addr_cnt_d;
  logic [9:0]      poll_q, poll_d;
  logic [9:0]      poll_inc;
  logic            lcd_rs_q, lcd_rs_d;
  logic            lcd_rw_q, lcd_rw_d;
  logic            lcd_e_q, lcd_e_d;
  logic            oe_q, oe_d;

  assign poll_inc = poll_q + 10'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    err_d       = err_q;
    timeout_d   = timeout_q;
    rd_data_d   = rd_data_q;
    busy_flag_d = busy_flag_q;
    addr_cnt_d  = addr_cnt_q;
    poll_d      = poll_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_rw_d    = lcd_rw_q;
    lcd_e_d     = lcd_e_q;
    oe_d        = oe_q;

    case (state_q)
      StIdle: begin
        if (bus.req) begin
          ready_d   = 1'b0;
          timeout_d = 1'b0;
          if (bus.op == 2'b11) begin
            // Illegal op: report immediately, bus untouched.
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = StSetup;
            cnt_d    = '0;
            op_d     = bus.op;
            err_d    = 1'b0;
            poll_d   = '0;
            lcd_rw_d = 1'b1;
            oe_d     = 1'b0;
            lcd_rs_d = (bus.op == 2'b01);
          end
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(T_AS - 1)) begin
          state_d = StEHi;
          cnt_d   = '0;
          lcd_e_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEHi: begin
        if (cnt_q == CntW'(T_PW - 1)) begin
          state_d   = StHold;
          cnt_d     = '0;
          lcd_e_d   = 1'b0;
          rd_data_d = lcd_db_in;
          if (!op_q[0]) begin
            busy_flag_d = lcd_db_in[7];
            addr_cnt_d  = lcd_db_in[6:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(T_H - 1)) begin
          cnt_d = '0;
          if (op_q == 2'b10) begin
            poll_d = poll_inc;
            if (!busy_flag_q) begin
              state_d = StDone;
            end else if (poll_inc == 10'(MAX_POLLS)) begin
              state_d   = StDone;
              timeout_d = 1'b1;
            end else begin
              state_d = StGap;
            end
          end else begin
            state_d = StDone;
          end
          if (state_d == StDone) begin
            done_d   = 1'b1;
            lcd_rw_d = 1'b0;
            lcd_rs_d = 1'b0;
            oe_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(T_GAP - 1)) begin
          state_d = StSetup;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset wins even mid-pulse: E drops immediately with no hold phase.
  always_ff @(posedge master_clk) begin
    if (rs) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      rd_data_q   <= 8'h00;
      busy_flag_q <= 1'b0;
      addr_cnt_q  <= 7'h00;
      poll_q      <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_rw_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      oe_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      rd_data_q   <= rd_data_d;
      busy_flag_q <= busy_flag_d;
      addr_cnt_q  <= addr_cnt_d;
      poll_q      <= poll_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_rw_q    <= lcd_rw_d;
      lcd_e_q     <= lcd_e_d;
      oe_q        <= oe_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.busy_flag  = busy_flag_q;
  assign bus.addr_cnt   = addr_cnt_q;
  assign bus.poll_count = poll_q;
  assign lcd_rs         = lcd_rs_q;
  assign lcd_rw         = lcd_rw_q;
  assign lcd_e          = lcd_e_q;
  assign lcd_db_oe      = oe_q;

endmodule

// File: tb/tb_lcd1602_reader.sv
// Directed bench for lcd1602_reader: single reads, polls, timeout, mid-pulse reset, illegal op.
module tb_lcd1602_reader;
  logic       clk;
  logic       rst;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db_in;
  logic       lcd_db_oe;

  int n_cmp;
  int n_err;
  logic [7:0] resp [0:7];

  lcd1602_reader_if bus ();

  lcd1602_reader #(
    .MAX_POLLS(4)
  ) u_dut (
    .master_clk(clk),
    .rs        (rst),
    .bus       (bus),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db_in (lcd_db_in),
    .lcd_db_oe (lcd_db_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Issue one op and watch the bus. Cycle 1 is the accept edge. lat=-1 if reset was injected.
  task automatic run_op(input logic [1:0] op, input bit inject_req, input int rst_at_ehi,
                        output int lat, output int first_e, output int pulses,
                        output int ehi, output int rs_hi, output int rw_hi);
    int  cyc;
    bit  prev;
    lat = 0; first_e = 0; pulses = 0; ehi = 0; rs_hi = 0; rw_hi = 0; prev = 1'b0;
    @(negedge clk);
    bus.op  = op;
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      if (lcd_e) begin
        ehi++;
        if (!prev) begin
          pulses++;
          if (first_e == 0) first_e = cyc;
          lcd_db_in = resp[(pulses - 1) % 8];
        end
      end
      if (lcd_rs) rs_hi++;
      if (lcd_rw) rw_hi++;
      prev = lcd_e;
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (inject_req && cyc == 8) begin
        bus.req = 1'b1;
        bus.op  = 2'b11;
      end
      if (inject_req && cyc == 9) bus.req = 1'b0;
      if (rst_at_ehi != 0 && ehi == rst_at_ehi) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        lat = -1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, fe, np, eh, rsh, rwh;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; bus.req = 1'b0; bus.op = 2'b00; lcd_db_in = 8'h00;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_poll", bus.poll_count, 0);
    check("rst_e", lcd_e, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_oe", lcd_db_oe, 1);

    // Reset during the 6th E-high cycle
    resp[0] = 8'hC3;
    run_op(2'b00, 1'b0, 6, lat, fe, np, eh, rsh, rwh);
    check("abort_path", lat, -1);
    check("abort_e", lcd_e, 0);
    check("abort_rw", lcd_rw, 0);
    check("abort_oe", lcd_db_oe, 1);
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_rd_data", bus.rd_data, 0);
    @(negedge clk);
    check("abort_no_done", bus.done, 0);

    // Status read
    resp[0] = 8'h8A;
    run_op(2'b00, 1'b0, 0, lat, fe, np, eh, rsh, rwh);
    check("st_latency", lat, 19);
    check("st_first_e", fe, 4);
    check("st_e_cycles", eh, 12);
    check("st_pulses", np, 1);
    check("st_rs_high", rsh, 0);
    check("st_rd_data", bus.rd_data, 8'h8A);
    check("st_bf", bus.busy_flag, 1);
    check("st_ac", bus.addr_cnt, 7'h0A);
    check("st_done_rw", lcd_rw, 0);
    check("st_done_oe", lcd_db_oe, 1);
    settle();
    check("st_ready_after", bus.ready, 1);
    check("st_done_pulse", bus.done, 0);

    // Data read, with a stray req while busy
    resp[0] = 8'h41;
    run_op(2'b01, 1'b1, 0, lat, fe, np, eh, rsh, rwh);
    check("dt_latency", lat, 19);
    check("dt_rs_high", rsh, 18);
    check("dt_pulses", np, 1);
    check("dt_rd_data", bus.rd_data, 8'h41);
    check("dt_bf_kept", bus.busy_flag, 1);
    check("dt_ac_kept", bus.addr_cnt, 7'h0A);
    check("dt_err", bus.err, 0);
    settle();

    // Poll: BF=1 three times, then clear with AC=5
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h05;
    run_op(2'b10, 1'b0, 0, lat, fe, np, eh, rsh, rwh);
    check("poll_latency", lat, 103);
    check("poll_pulses", np, 4);
    check("poll_count", bus.poll_count, 4);
    check("poll_timeout", bus.timeout, 0);
    check("poll_ac", bus.addr_cnt, 5);
    check("poll_bf", bus.busy_flag, 0);
    settle();

    // Poll with BF stuck high hits MAX_POLLS=4
    for (int i = 0; i < 8; i++) resp[i] = 8'hFF;
    run_op(2'b10, 1'b0, 0, lat, fe, np, eh, rsh, rwh);
    check("to_latency", lat, 103);
    check("to_pulses", np, 4);
    check("to_timeout", bus.timeout, 1);
    check("to_count", bus.poll_count, 4);
    check("to_bf", bus.busy_flag, 1);
    settle();
    check("to_timeout_held", bus.timeout, 1);

    // Illegal op
    run_op(2'b11, 1'b0, 0, lat, fe, np, eh, rsh, rwh);
    check("ill_latency", lat, 1);
    check("ill_err", bus.err, 1);
    check("ill_timeout_clr", bus.timeout, 0);
    check("ill_pulses", np, 0);
    check("ill_rw", rwh, 0);
    settle();
    check("ill_ready", bus.ready, 1);
    check("ill_err_held", bus.err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
